// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 4;
endpackage

// File: rtl/dmem_array.sv
// Word array: byte-enabled synchronous write and registered read, one cycle.
// No backpressure; the read register clears on demand so responses can return to zero.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int n          = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic                      re,
  input  logic                      clr,
  input  logic [DEPTH_LOG2-1:0]     addr,
  input  logic [n-1:0]              wdata,
  input  logic [BYTES_PER_WORD-1:0] be,
  output logic [n-1:0]              rdata
);
  localparam int BW = n / BYTES_PER_WORD;

  logic [n-1:0] mem [2**DEPTH_LOG2];

  // Storage is deliberately not reset so contents survive a core reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (be[i]) mem[addr][i*BW +: BW] <= wdata[i*BW +: BW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   rdata <= '0;
    else if (re)  rdata <= mem[addr];
    else if (clr) rdata <= '0;
  end
endmodule

// File: rtl/dmem_responder.sv
// Blocking data-memory responder: one request at a time, LATENCY wait states, then a held response.
// Latency LATENCY+1 cycles to resp_valid; req_ready low from acceptance until the response handshake.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int n          = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_wdata,
  input  logic [3:0]   req_be,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [n-1:0] resp_rdata,
  output logic         resp_err
);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cap_write;
  logic [n-1:0]     cap_addr;
  logic [n-1:0]     cap_wdata;
  logic [3:0]       cap_be;

  logic             a_write;
  logic [n-1:0]     a_addr;
  logic [n-1:0]     a_wdata;
  logic [3:0]       a_be;
  logic             access;
  logic             fault;
  logic             ack;

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign ack        = resp_valid & resp_ready;

  // With zero wait states the access happens on the acceptance edge, straight from the request.
  assign a_write = (LATENCY == 0) ? req_write : cap_write;
  assign a_addr  = (LATENCY == 0) ? req_addr  : cap_addr;
  assign a_wdata = (LATENCY == 0) ? req_wdata : cap_wdata;
  assign a_be    = (LATENCY == 0) ? req_be    : cap_be;
  assign access  = (LATENCY == 0) ? (req_valid & req_ready)
                                  : ((state == ST_WAIT) && (cnt == '0));

  assign fault = (a_addr[1:0] != 2'b00) || ((a_addr >> (DEPTH_LOG2 + 2)) != '0);

  dmem_array #(
    .n          (n),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (access & a_write & ~fault),
    .re    (access & ~a_write & ~fault),
    .clr   ((access & (a_write | fault)) | ack),
    .addr  (a_addr[DEPTH_LOG2+1:2]),
    .wdata (a_wdata),
    .be    (a_be),
    .rdata (resp_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
            if (LATENCY == 0) begin
              state    <= ST_RESP;
              resp_err <= fault;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state    <= ST_RESP;
            resp_err <= fault;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state    <= ST_IDLE;
            resp_err <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance [0] and a LATENCY=0 instance [1],
// checked each cycle against a transaction-level model plus directed literal expectations.
module tb_dmem_responder;
  localparam int NI = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_write  [NI];
  logic [31:0] req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic [3:0]  req_be     [NI];
  logic        resp_valid [NI];
  logic        resp_ready [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_err   [NI];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.n(32), .DEPTH_LOG2(8), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.n(32), .DEPTH_LOG2(8), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  // Transaction-level model: a pending request counts down edges to its access, then a held response.
  bit          m_busy  [NI];
  bit          m_valid [NI];
  bit          m_wr    [NI];
  bit          m_err   [NI];
  bit [31:0]   m_rd    [NI];
  int          m_left  [NI];
  logic [31:0] m_addr  [NI];
  logic [31:0] m_wd    [NI];
  logic [3:0]  m_be    [NI];
  logic [31:0] m_mem   [NI][256];
  bit          m_go;
  logic [7:0]  m_w;

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) begin
        m_busy[k] = 0; m_valid[k] = 0; m_rd[k] = 0; m_err[k] = 0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        m_go = 0;
        if (m_valid[k]) begin
          if (resp_ready[k]) begin
            m_valid[k] = 0; m_rd[k] = 0; m_err[k] = 0;
          end
        end else if (m_busy[k]) begin
          m_left[k] = m_left[k] - 1;
          if (m_left[k] == 0) m_go = 1;
        end else if (req_valid[k]) begin
          m_wr[k] = req_write[k]; m_addr[k] = req_addr[k];
          m_wd[k] = req_wdata[k]; m_be[k] = req_be[k];
          if (lat_of(k) == 0) m_go = 1;
          else begin m_busy[k] = 1; m_left[k] = lat_of(k); end
        end
        if (m_go) begin
          m_busy[k]  = 0;
          m_valid[k] = 1;
          m_err[k]   = (m_addr[k] % 4 != 0) || (m_addr[k] >= 32'd1024);
          m_rd[k]    = 0;
          m_w        = m_addr[k][9:2];
          if (!m_err[k]) begin
            if (m_wr[k]) begin
              for (int b = 0; b < 4; b++)
                if (m_be[k][b]) m_mem[k][m_w][8*b +: 8] = m_wd[k][8*b +: 8];
            end else begin
              m_rd[k] = m_mem[k][m_w];
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, k, $time, act, exp);
    end
  endtask

  task automatic tmo(input string name, input int k);
    n_tests++;
    n_fail++;
    $display("FAIL %s[%0d] at %0t: no handshake within 50 cycles", name, k, $time);
  endtask

  task automatic issue(input int k, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be);
    int g;
    @(posedge clk); #1;
    req_valid[k] = 1; req_write[k] = wr; req_addr[k] = a; req_wdata[k] = wd; req_be[k] = be;
    for (g = 0; g < 50; g++) begin
      @(negedge clk);
      if (req_ready[k]) break;
    end
    if (g == 50) tmo("accept", k);
    @(posedge clk); #1;
    // Scramble the request after acceptance; only the acceptance edge may matter.
    req_valid[k] = 0; req_write[k] = ~wr; req_addr[k] = ~a; req_wdata[k] = ~wd; req_be[k] = ~be;
  endtask

  task automatic wait_resp(input int k, output logic [31:0] rd, output logic err, output int lat);
    lat = 0; rd = '0; err = 0;
    for (int g = 0; g < 50; g++) begin
      @(negedge clk);
      if (resp_valid[k]) begin
        rd = resp_rdata[k]; err = resp_err[k];
        return;
      end
      @(posedge clk); #1;
      lat++;
    end
    tmo("resp", k);
  endtask

  task automatic finish_resp(input int k);
    resp_ready[k] = 1;
    @(posedge clk); #1;
  endtask

  task automatic txn(input int k, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd, output logic err, output int lat);
    issue(k, wr, a, wd, be);
    wait_resp(k, rd, err, lat);
    finish_resp(k);
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  int          acc;
  int          rv;

  initial begin
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 0; req_write[k] = 0; req_addr[k] = '0;
      req_wdata[k] = '0; req_be[k] = '0; resp_ready[k] = 1;
    end
    #1 rst_n = 1'b0;

    fork
      forever begin
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
          chk("req_ready",  k, 32'(req_ready[k]),  32'(!(m_busy[k] || m_valid[k])));
          chk("resp_valid", k, 32'(resp_valid[k]), 32'(m_valid[k]));
          chk("resp_rdata", k, resp_rdata[k],      m_rd[k]);
          chk("resp_err",   k, 32'(resp_err[k]),   32'(m_err[k]));
        end
      end
    join_none

    // Held in reset while a request is being presented.
    @(posedge clk); #1;
    req_valid[0] = 1; req_write[0] = 1; req_addr[0] = 32'h10; req_be[0] = 4'hF;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; req_valid[0] = 0;
    @(negedge clk);
    chk("rst_req_ready",  0, 32'(req_ready[0]),  32'd1);
    chk("rst_resp_valid", 0, 32'(resp_valid[0]), 32'd0);
    chk("rst_resp_rdata", 0, resp_rdata[0],      32'd0);
    chk("rst_resp_err",   0, 32'(resp_err[0]),   32'd0);

    txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, lat);
    chk("lat2_edges", 0, 32'(lat), 32'd2);
    chk("store_err",  0, 32'(err), 32'd0);
    chk("store_rd",   0, rd,       32'd0);
    txn(0, 1, 32'h10, 32'h00000055, 4'b0001, rd, err, lat);
    txn(0, 0, 32'h10, 32'h0, 4'h0, rd, err, lat);
    chk("merge_rd",  0, rd,       32'hDEADBE55);
    chk("merge_err", 0, 32'(err), 32'd0);

    txn(0, 1, 32'h10, 32'h0, 4'h0, rd, err, lat);
    chk("be0_err", 0, 32'(err), 32'd0);
    txn(0, 1, 32'h0,  32'h11223344, 4'hF, rd, err, lat);
    txn(0, 1, 32'h20, 32'hAAAAAAAA, 4'hF, rd, err, lat);

    txn(0, 0, 32'h13, 32'h0, 4'h0, rd, err, lat);
    chk("misalign_err", 0, 32'(err), 32'd1);
    chk("misalign_rd",  0, rd,       32'd0);
    txn(0, 0, 32'h400, 32'h0, 4'h0, rd, err, lat);
    chk("range_err", 0, 32'(err), 32'd1);
    chk("range_rd",  0, rd,       32'd0);
    txn(0, 1, 32'h400, 32'hBADBAD00, 4'hF, rd, err, lat);
    chk("range_st_err", 0, 32'(err), 32'd1);
    txn(0, 1, 32'h11, 32'hBADBAD00, 4'hF, rd, err, lat);
    chk("mis_st_err", 0, 32'(err), 32'd1);
    txn(0, 0, 32'h0, 32'h0, 4'h0, rd, err, lat);
    chk("alias0_rd", 0, rd, 32'h11223344);
    txn(0, 0, 32'h10, 32'h0, 4'h0, rd, err, lat);
    chk("alias10_rd", 0, rd, 32'hDEADBE55);

    // Response held off for five cycles while a new request waits.
    resp_ready[0] = 0;
    issue(0, 0, 32'h0, 32'h0, 4'h0);
    wait_resp(0, rd, err, lat);
    chk("hold_first_rd", 0, rd, 32'h11223344);
    @(posedge clk); #1;
    req_valid[0] = 1; req_write[0] = 1; req_addr[0] = 32'h0; req_wdata[0] = 32'hFFFFFFFF; req_be[0] = 4'hF;
    repeat (5) begin
      @(negedge clk);
      chk("hold_vld", 0, 32'(resp_valid[0]), 32'd1);
      chk("hold_rd",  0, resp_rdata[0],      32'h11223344);
      chk("hold_rdy", 0, 32'(req_ready[0]),  32'd0);
    end
    @(posedge clk); #1 resp_ready[0] = 1;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_rdy", 0, 32'(req_ready[0]),  32'd1);
    chk("post_hs_vld", 0, 32'(resp_valid[0]), 32'd0);
    @(posedge clk); #1 req_valid[0] = 0;
    wait_resp(0, rd, err, lat);
    finish_resp(0);
    txn(0, 0, 32'h0, 32'h0, 4'h0, rd, err, lat);
    chk("held_store_rd", 0, rd, 32'hFFFFFFFF);

    // Reset during the wait states of a store discards it.
    issue(0, 1, 32'h20, 32'h12345678, 4'hF);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    txn(0, 0, 32'h20, 32'h0, 4'h0, rd, err, lat);
    chk("rst_wait_rd", 0, rd, 32'hAAAAAAAA);

    // Reset while the response is held keeps the committed store.
    resp_ready[0] = 0;
    issue(0, 1, 32'h30, 32'h5A5A5A5A, 4'hF);
    wait_resp(0, rd, err, lat);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; resp_ready[0] = 1;
    txn(0, 0, 32'h30, 32'h0, 4'h0, rd, err, lat);
    chk("rst_resp_rd", 0, rd, 32'h5A5A5A5A);

    // Zero-wait-state instance.
    txn(1, 1, 32'h10, 32'hCAFEF00D, 4'hF, rd, err, lat);
    chk("lat0_edges", 1, 32'(lat), 32'd0);
    txn(1, 0, 32'h10, 32'h0, 4'h0, rd, err, lat);
    chk("lat0_rd", 1, rd, 32'hCAFEF00D);
    @(posedge clk); #1;
    req_valid[1] = 1; req_write[1] = 0; req_addr[1] = 32'h10; resp_ready[1] = 1;
    acc = 0; rv = 0;
    repeat (8) begin
      @(negedge clk);
      if (req_ready[1] && req_valid[1]) acc++;
      if (resp_valid[1]) rv++;
    end
    @(posedge clk); #1 req_valid[1] = 0;
    repeat (2) @(posedge clk);
    chk("b2b_accepts", 1, 32'(acc), 32'd4);
    chk("b2b_resps",   1, 32'(rv),  32'd4);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
